// File: rtl/stream_collector_pkg.sv
// Shared types and helpers for the stream collector: FSM state encoding and id-width helper.
package stream_collector_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  function automatic int sid_width(input int ns);
    return (ns > 1) ? $clog2(ns) : 1;
  endfunction

endpackage

// File: rtl/stream_collector_if.sv
// NS-to-1 stream bus: per-source valid/ready/last/data in, one registered beat out with its source id.
interface stream_collector_if
  import stream_collector_pkg::*;
#(
  parameter int NS = 2,
  parameter int DW = 32
);
  localparam int SW = sid_width(NS);

  logic [NS-1:0]    in_vld;
  logic [NS-1:0]    in_rdy;
  logic [NS-1:0]    in_lst;
  logic [NS*DW-1:0] in_dat;
  logic             out_vld;
  logic             out_rdy;
  logic             out_lst;
  logic [SW-1:0]    out_sid;
  logic [DW-1:0]    out_dat;

  modport slave (
    input  in_vld, in_lst, in_dat, out_rdy,
    output in_rdy, out_vld, out_lst, out_sid, out_dat
  );

  modport master (
    output in_vld, in_lst, in_dat, out_rdy,
    input  in_rdy, out_vld, out_lst, out_sid, out_dat
  );
endinterface

// File: rtl/stream_collector_rr_arb.sv
// Rotating-priority one-hot arbiter: the first request found scanning ptr+1, ptr+2, ... (mod NS) wins.
module stream_rr_arb #(
  parameter int NS = 2,
  parameter int SW = 1
) (
  input  logic [NS-1:0] req,
  input  logic [SW-1:0] ptr,
  output logic [NS-1:0] gnt
);

  logic [SW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NS; k++) begin
      idx = SW'((int'(ptr) + k) % NS);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_collector.sv
// Packet-aware round-robin merge of NS streams into one registered output stream tagged with source id.
module stream_collector
  import stream_collector_pkg::*;
#(
  parameter int NS = 2,
  parameter int DW = 32
) (
  input logic            clk,
  input logic            clk_en,
  input logic            rst,
  stream_collector_if.slave bus
);
  localparam int SW = sid_width(NS);

  state_e        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] lock_q, lock_d;
  logic          out_vld_q, out_vld_d;
  logic          out_lst_q, out_lst_d;
  logic [SW-1:0] out_sid_q, out_sid_d;
  logic [DW-1:0] out_dat_q, out_dat_d;

  logic [NS-1:0] arb_gnt, gnt, rdy;
  logic          ld, acc, win_lst;
  logic [SW-1:0] win_sid;
  logic [DW-1:0] win_dat;

  stream_rr_arb #(.NS(NS), .SW(SW)) u_arb (
    .req(bus.in_vld),
    .ptr(ptr_q),
    .gnt(arb_gnt)
  );

  // While locked only the owning source can be granted, valid or not.
  assign gnt = (state_q == LOCK) ? ({{(NS-1){1'b0}}, 1'b1} << lock_q) : arb_gnt;
  assign ld  = clk_en & rst & (~out_vld_q | bus.out_rdy);
  assign rdy = ld ? gnt : '0;
  assign acc = |(bus.in_vld & rdy);

  always_comb begin
    win_sid = '0;
    win_dat = '0;
    win_lst = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (gnt[s]) begin
        win_sid = SW'(s);
        win_dat = bus.in_dat[s*DW +: DW];
        win_lst = bus.in_lst[s];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    out_vld_d = out_vld_q;
    out_lst_d = out_lst_q;
    out_sid_d = out_sid_q;
    out_dat_d = out_dat_q;
    if (ld) begin
      out_vld_d = acc;
    end
    if (acc) begin
      out_lst_d = win_lst;
      out_sid_d = win_sid;
      out_dat_d = win_dat;
      case (state_q)
        IDLE: begin
          ptr_d = win_sid;
          if (!win_lst) begin
            state_d = LOCK;
            lock_d  = win_sid;
          end
        end
        LOCK: begin
          if (win_lst) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= SW'(NS - 1);
      lock_q    <= '0;
      out_vld_q <= 1'b0;
      out_lst_q <= 1'b0;
      out_sid_q <= '0;
      out_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      out_vld_q <= out_vld_d;
      out_lst_q <= out_lst_d;
      out_sid_q <= out_sid_d;
      out_dat_q <= out_dat_d;
    end
  end

  assign bus.in_rdy  = rdy;
  assign bus.out_vld = out_vld_q;
  assign bus.out_lst = out_lst_q;
  assign bus.out_sid = out_sid_q;
  assign bus.out_dat = out_dat_q;

endmodule

// File: tb/tb_stream_collector.sv
// Bench for stream_collector (NS=4): directed vector table, clk_en freeze sequence, random traffic vs model.
module tb_stream_collector;
  import stream_collector_pkg::*;

  localparam int NS = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic clk_en;
  logic rst;

  stream_collector_if #(.NS(NS), .DW(DW)) bus ();

  stream_collector #(.NS(NS), .DW(DW)) dut (
    .clk   (clk),
    .clk_en(clk_en),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic       rst;
    logic       ce;
    logic       ordy;
    logic [3:0] vld;
    logic [3:0] lst;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] sid;
    logic       ol;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic ce, input logic ordy,
                              input logic [3:0] vld, input logic [3:0] lst, input logic [3:0] rdy,
                              input logic ov, input logic [1:0] sid, input logic ol);
    vec_t v;
    v.rst = r; v.ce = ce; v.ordy = ordy; v.vld = vld; v.lst = lst;
    v.rdy = rdy; v.ov = ov; v.sid = sid; v.ol = ol;
    return v;
  endfunction

  // One cycle of fixed stimulus with data 0xA0+s; ready checked before the edge, outputs after it.
  task automatic apply(input vec_t v, input string tag);
    logic [31:0] ed;
    @(negedge clk);
    rst         = v.rst;
    clk_en      = v.ce;
    bus.out_rdy = v.ordy;
    bus.in_vld  = v.vld;
    bus.in_lst  = v.lst;
    for (int s = 0; s < NS; s++) bus.in_dat[s*DW +: DW] = 32'hA0 + 32'(s);
    #1;
    check({tag, " in_rdy"}, 64'(bus.in_rdy), 64'(v.rdy));
    @(posedge clk);
    #1;
    check({tag, " out_vld"}, 64'(bus.out_vld), 64'(v.ov));
    check({tag, " out_sid"}, 64'(bus.out_sid), 64'(v.sid));
    check({tag, " out_lst"}, 64'(bus.out_lst), 64'(v.ol));
    if (v.ov) begin
      ed = 32'hA0 + 32'(v.sid);
      check({tag, " out_dat"}, 64'(bus.out_dat), 64'(ed));
    end
  endtask

  // Reference arbitration: first present source after the last winner.
  function automatic logic [3:0] scan(input logic [3:0] r, input int p);
    for (int k = 1; k <= NS; k++)
      if (r[(p + k) % NS]) return 4'b0001 << ((p + k) % NS);
    return 4'b0000;
  endfunction

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       q[NS][$];
  logic [3:0]  pres;
  int          m_ptr, m_lsid, m_sid, a;
  logic        m_lock, m_ov, m_ol, ld, gen;
  logic [31:0] m_dat;
  logic [3:0]  er, amask;
  beat_t       b;

  initial begin
    rst         = 1'b0;
    clk_en      = 1'b1;
    bus.out_rdy = 1'b1;
    bus.in_vld  = '0;
    bus.in_lst  = '0;
    bus.in_dat  = '0;

    // reset with all sources valid, then strict rotation of single beats
    tbl.push_back(mk(0, 1, 1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'b1111, 4'b1111, 4'b0001, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 4'b1111, 4'b1111, 4'b0010, 1, 1, 1));
    tbl.push_back(mk(1, 1, 1, 4'b1111, 4'b1111, 4'b0100, 1, 2, 1));
    tbl.push_back(mk(1, 1, 1, 4'b1111, 4'b1111, 4'b1000, 1, 3, 1));
    tbl.push_back(mk(1, 1, 1, 4'b1111, 4'b1111, 4'b0001, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 4'b0010, 4'b1111, 4'b0010, 1, 1, 1));
    // src2 three-beat packet with src0/src1 waiting and a gap on src2
    tbl.push_back(mk(1, 1, 1, 4'b0111, 4'b0011, 4'b0100, 1, 2, 0));
    tbl.push_back(mk(1, 1, 1, 4'b0011, 4'b0011, 4'b0100, 0, 2, 0));
    tbl.push_back(mk(1, 1, 1, 4'b0111, 4'b0011, 4'b0100, 1, 2, 0));
    tbl.push_back(mk(1, 1, 1, 4'b0111, 4'b0111, 4'b0100, 1, 2, 1));
    tbl.push_back(mk(1, 1, 1, 4'b1011, 4'b1111, 4'b1000, 1, 3, 1));
    tbl.push_back(mk(1, 1, 1, 4'b0011, 4'b1111, 4'b0001, 1, 0, 1));
    // output stall holds the register and blocks all sources
    tbl.push_back(mk(1, 1, 0, 4'b0010, 4'b1111, 4'b0000, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 4'b0010, 4'b1111, 4'b0010, 1, 1, 1));
    // reset in the middle of a src1 packet
    tbl.push_back(mk(1, 1, 1, 4'b0001, 4'b0001, 4'b0001, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 4'b0011, 4'b0000, 4'b0010, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 4'b0011, 4'b0000, 4'b0010, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 4'b0011, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'b0011, 4'b0001, 4'b0001, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 4'b0010, 4'b0010, 4'b0010, 1, 1, 1));
    tbl.push_back(mk(1, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // clk_en low for 3 cycles inside a src2 packet
    apply(mk(1, 1, 1, 4'b0100, 4'b0000, 4'b0100, 1, 2, 0), "freeze_start");
    for (int i = 0; i < 3; i++)
      apply(mk(1, 0, 1, 4'b0101, 4'b0000, 4'b0000, 1, 2, 0), $sformatf("freeze%0d", i));
    apply(mk(1, 1, 1, 4'b0101, 4'b0100, 4'b0100, 1, 2, 1), "freeze_resume");
    apply(mk(1, 1, 1, 4'b0001, 4'b0001, 4'b0001, 1, 0, 1), "freeze_after");

    // random traffic against the transaction-level model
    apply(mk(0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0), "rand_reset");
    m_ptr = NS - 1; m_lock = 1'b0; m_lsid = 0;
    m_ov = 1'b0; m_ol = 1'b0; m_sid = 0; m_dat = '0;
    pres = '0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      gen = (cyc < 2500);
      if (!gen && pres == 0 && !m_ov &&
          q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && q[3].size() == 0) break;
      @(negedge clk);
      for (int s = 0; s < NS; s++) begin
        if (gen && q[s].size() < 3 && $urandom_range(7) == 0) begin
          int len;
          len = $urandom_range(1, 3);
          for (int k = 0; k < len; k++) begin
            b.d = $urandom;
            b.l = (k == len - 1);
            q[s].push_back(b);
          end
        end
        if (!pres[s] && q[s].size() > 0 && $urandom_range(3) != 0) pres[s] = 1'b1;
        bus.in_vld[s] = pres[s];
        bus.in_lst[s] = pres[s] ? q[s][0].l : 1'($urandom);
        bus.in_dat[s*DW +: DW] = pres[s] ? q[s][0].d : $urandom;
      end
      rst         = 1'b1;
      bus.out_rdy = 1'($urandom);
      clk_en      = ($urandom_range(15) != 0);
      #1;
      ld    = clk_en && (!m_ov || bus.out_rdy);
      er    = ld ? (m_lock ? (4'b0001 << m_lsid) : scan(pres, m_ptr)) : 4'b0000;
      amask = er & pres;
      check("rand in_rdy", 64'(bus.in_rdy), 64'(er));
      check("rand out_vld", 64'(bus.out_vld), 64'(m_ov));
      check("rand out_sid", 64'(bus.out_sid), 64'(m_sid));
      check("rand out_lst", 64'(bus.out_lst), 64'(m_ol));
      check("rand out_dat", 64'(bus.out_dat), 64'(m_dat));
      @(posedge clk);
      if (ld) begin
        m_ov = (amask != 0);
        if (amask != 0) begin
          a = 0;
          for (int s = 0; s < NS; s++) if (amask[s]) a = s;
          b     = q[a].pop_front();
          pres[a] = 1'b0;
          m_sid = a;
          m_dat = b.d;
          m_ol  = b.l;
          if (!m_lock) begin
            m_ptr = a;
            if (!b.l) begin
              m_lock = 1'b1;
              m_lsid = a;
            end
          end else if (b.l) begin
            m_lock = 1'b0;
          end
        end
      end
    end
    check("rand drained", 64'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
